// File: rtl/and_share_arbiter_pkg.sv
// and_share_arbiter_pkg: shared state type and default sizing for the AND-share arbiter
package and_share_arbiter_pkg;
  localparam int N_REQ_DEF = 4;
  localparam int W_DEF = 8;
  localparam int CNT_W = 16;
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/and_share_arbiter_rr_pick.sv
// rr_pick: round-robin one-hot winner search starting after the last served requester
module rr_pick
  import and_share_arbiter_pkg::*;
#(
  parameter int N = N_REQ_DEF,
  parameter int LW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last,
  output logic [N-1:0]  win,
  output logic          any_req
);
  assign any_req = |req;
  always_comb begin
    win = '0;
    for (int k = N; k >= 1; k--)
      win = req[(int'(last) + k) % N] ? N'(1) << ((int'(last) + k) % N) : win;
  end
endmodule

// File: rtl/and_share_arbiter.sv
// and_share_arbiter: round-robin arbiter sharing one registered AND unit among N_REQ requesters
module and_share_arbiter
  import and_share_arbiter_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int W = W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] x,
  input  logic [N_REQ*W-1:0] y,
  output logic [N_REQ-1:0]   grant,
  output logic [N_REQ-1:0]   ack,
  output logic [W-1:0]       z,
  output logic               z_valid,
  output logic               busy,
  output logic [CNT_W-1:0]   op_count
);
  localparam int LW = $clog2(N_REQ);
  state_t state;
  logic [LW-1:0] last;
  logic [LW-1:0] gidx;
  logic [LW-1:0] widx;
  logic [N_REQ-1:0] win;
  logic any_req;
  logic [W-1:0] lx;
  logic [W-1:0] ly;
  rr_pick #(.N(N_REQ), .LW(LW)) u_pick (
    .req(req),
    .last(last),
    .win(win),
    .any_req(any_req)
  );
  always_comb begin
    gidx = '0;
    widx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      gidx = grant[i] ? LW'(i) : gidx;
      widx = win[i] ? LW'(i) : widx;
    end
  end
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= '0;
      ack <= '0;
      z <= '0;
      z_valid <= 1'b0;
      op_count <= '0;
      last <= LW'(N_REQ - 1);
      lx <= '0;
      ly <= '0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          grant <= win;
          lx <= x[widx*W +: W];
          ly <= y[widx*W +: W];
          state <= EXEC;
        end
        EXEC: begin
          z <= lx & ly;
          ack <= grant;
          z_valid <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          ack <= '0;
          z_valid <= 1'b0;
          grant <= '0;
          last <= gidx;
          op_count <= op_count + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_and_share_arbiter.sv
// tb_and_share_arbiter: scoreboard-driven scenario bench for and_share_arbiter
module tb_and_share_arbiter;
  typedef struct {
    int idx;
    logic [7:0] z;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] req = '0;
  logic [31:0] x = '0;
  logic [31:0] y = '0;
  logic [3:0] grant;
  logic [3:0] ack;
  logic [7:0] z;
  logic z_valid;
  logic busy;
  logic [15:0] op_count;
  exp_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  and_share_arbiter #(.N_REQ(4), .W(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .x(x),
    .y(y),
    .grant(grant),
    .ack(ack),
    .z(z),
    .z_valid(z_valid),
    .busy(busy),
    .op_count(op_count)
  );
  always #5 clk = ~clk;
  function automatic int rr_model(input logic [3:0] r, input int lst);
    for (int k = 1; k <= 4; k++)
      if (r[(lst + k) % 4]) return (lst + k) % 4;
    return -1;
  endfunction
  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    x = '0;
    y = '0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    req = 4'b1111;
    x = $urandom;
    y = $urandom;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (grant !== 4'b0000) begin miscompares++; $display("FAIL reset_grant got %b want 0000", grant); end
    vectors++;
    if (ack !== 4'b0000) begin miscompares++; $display("FAIL reset_ack got %b want 0000", ack); end
    vectors++;
    if (z !== 8'h00) begin miscompares++; $display("FAIL reset_z got %h want 00", z); end
    vectors++;
    if (z_valid !== 1'b0) begin miscompares++; $display("FAIL reset_z_valid got %b want 0", z_valid); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++;
    if (op_count !== 16'h0000) begin miscompares++; $display("FAIL reset_op_count got %h want 0000", op_count); end
    req = '0;
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_no_req_busy got %b want 0", busy); end
  endtask
  task automatic test_basic();
    exp_t e;
    do_reset();
    x[7:0] = 8'hF0;
    y[7:0] = 8'h3C;
    req = 4'b0001;
    exp_q.push_back('{0, 8'h30});
    @(negedge clk);
    vectors++;
    if (grant !== 4'b0001 || busy !== 1'b1 || z_valid !== 1'b0) begin
      miscompares++; $display("FAIL basic_exec grant=%b busy=%b zv=%b want 0001/1/0", grant, busy, z_valid);
    end
    @(negedge clk);
    e = exp_q.pop_front();
    vectors++;
    if (z_valid !== 1'b1 || ack !== 4'(1 << e.idx)) begin
      miscompares++; $display("FAIL basic_ack ack=%b zv=%b want %b/1", ack, z_valid, 4'(1 << e.idx));
    end
    vectors++;
    if (z !== e.z) begin miscompares++; $display("FAIL basic_z got %h want %h", z, e.z); end
    req = '0;
    @(negedge clk);
    vectors++;
    if (op_count !== 16'd1 || grant !== 4'b0000 || ack !== 4'b0000 || busy !== 1'b0) begin
      miscompares++; $display("FAIL basic_done op=%0d grant=%b ack=%b busy=%b want 1/0000/0000/0", op_count, grant, ack, busy);
    end
    vectors++;
    if (z !== 8'h30 || z_valid !== 1'b0) begin
      miscompares++; $display("FAIL basic_z_hold z=%h zv=%b want 30/0", z, z_valid);
    end
  endtask
  task automatic test_round_robin();
    exp_t e;
    int w;
    int m_last;
    do_reset();
    x = $urandom;
    y = $urandom;
    req = 4'b1111;
    m_last = 3;
    w = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c % 3 == 0) begin
        w = rr_model(req, m_last);
        exp_q.push_back('{w, x[w*8 +: 8] & y[w*8 +: 8]});
        vectors++;
        if (grant !== 4'(1 << w)) begin miscompares++; $display("FAIL rr_grant c=%0d got %b want %b", c, grant, 4'(1 << w)); end
      end else if (c % 3 == 1) begin
        e = exp_q.pop_front();
        vectors++;
        if (ack !== 4'(1 << e.idx) || z !== e.z || z_valid !== 1'b1) begin
          miscompares++; $display("FAIL rr_result c=%0d ack=%b z=%h zv=%b want %b/%h/1", c, ack, z, z_valid, 4'(1 << e.idx), e.z);
        end
      end else begin
        m_last = w;
        vectors++;
        if (grant !== 4'b0000 || ack !== 4'b0000) begin
          miscompares++; $display("FAIL rr_idle c=%0d grant=%b ack=%b want 0000/0000", c, grant, ack);
        end
      end
    end
    vectors++;
    if (op_count !== 16'd4) begin miscompares++; $display("FAIL rr_op_count got %0d want 4", op_count); end
    @(negedge clk);
    vectors++;
    if (grant !== 4'(1 << rr_model(req, m_last))) begin
      miscompares++; $display("FAIL rr_wrap_grant got %b want 0001", grant);
    end
    req = '0;
    repeat (2) @(negedge clk);
  endtask
  task automatic test_latch();
    exp_t e;
    int pulses;
    do_reset();
    x[23:16] = 8'hFF;
    y[23:16] = 8'hAA;
    req = 4'b0100;
    exp_q.push_back('{2, 8'hAA});
    @(negedge clk);
    vectors++;
    if (grant !== 4'b0100) begin miscompares++; $display("FAIL latch_grant got %b want 0100", grant); end
    x[23:16] = 8'h00;
    req = '0;
    pulses = 0;
    @(negedge clk);
    e = exp_q.pop_front();
    vectors++;
    if (z !== e.z || z_valid !== 1'b1) begin miscompares++; $display("FAIL latch_z z=%h zv=%b want %h/1", z, z_valid, e.z); end
    for (int c = 0; c < 4; c++) begin
      pulses += int'(ack[2]);
      @(negedge clk);
    end
    vectors++;
    if (pulses != 1) begin miscompares++; $display("FAIL latch_ack_pulses got %0d want 1", pulses); end
    vectors++;
    if (z !== 8'hAA || busy !== 1'b0) begin miscompares++; $display("FAIL latch_hold z=%h busy=%b want aa/0", z, busy); end
  endtask
  task automatic test_reset_mid();
    exp_t e;
    do_reset();
    x[7:0] = 8'h5A;
    y[7:0] = 8'h0F;
    req = 4'b0001;
    repeat (2) @(negedge clk);
    req = '0;
    @(negedge clk);
    vectors++;
    if (op_count !== 16'd1) begin miscompares++; $display("FAIL mid_pre_count got %0d want 1", op_count); end
    x[15:8] = 8'hC3;
    y[15:8] = 8'h7E;
    req = 4'b0010;
    @(negedge clk);
    vectors++;
    if (grant !== 4'b0010) begin miscompares++; $display("FAIL mid_grant got %b want 0010", grant); end
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (grant !== 4'b0000 || ack !== 4'b0000 || z !== 8'h00 || z_valid !== 1'b0 || busy !== 1'b0 || op_count !== 16'd0) begin
      miscompares++; $display("FAIL mid_abort grant=%b ack=%b z=%h zv=%b busy=%b op=%0d want all 0", grant, ack, z, z_valid, busy, op_count);
    end
    exp_q.delete();
    @(negedge clk);
    vectors++;
    if (ack !== 4'b0000) begin miscompares++; $display("FAIL mid_no_ack got %b want 0000", ack); end
    rst_n = 1'b1;
    exp_q.push_back('{1, 8'h42});
    @(negedge clk);
    vectors++;
    if (grant !== 4'b0010) begin miscompares++; $display("FAIL mid_regrant got %b want 0010", grant); end
    @(negedge clk);
    e = exp_q.pop_front();
    vectors++;
    if (ack !== 4'(1 << e.idx) || z !== e.z) begin
      miscompares++; $display("FAIL mid_result ack=%b z=%h want %b/%h", ack, z, 4'(1 << e.idx), e.z);
    end
    req = '0;
    @(negedge clk);
    vectors++;
    if (op_count !== 16'd1) begin miscompares++; $display("FAIL mid_post_count got %0d want 1", op_count); end
  endtask
  task automatic test_wrap();
    do_reset();
    @(negedge clk);
    force dut.op_count = 16'hFFFF;
    #1 release dut.op_count;
    req = 4'b0001;
    repeat (2) @(negedge clk);
    req = '0;
    @(negedge clk);
    vectors++;
    if (op_count !== 16'h0000) begin miscompares++; $display("FAIL wrap_count got %h want 0000", op_count); end
  endtask
  task automatic test_back_to_back();
    exp_t e;
    int m_last;
    int w;
    do_reset();
    x = 32'h9C_00_00_E7;
    y = 32'h35_00_00_5B;
    req = 4'b0001;
    repeat (2) @(negedge clk);
    req = 4'b1001;
    m_last = 0;
    @(negedge clk);
    vectors++;
    if (grant !== 4'b0000) begin miscompares++; $display("FAIL b2b_gap got %b want 0000", grant); end
    for (int op = 0; op < 2; op++) begin
      w = rr_model(req, m_last);
      exp_q.push_back('{w, x[w*8 +: 8] & y[w*8 +: 8]});
      @(negedge clk);
      vectors++;
      if (grant !== 4'(1 << w)) begin miscompares++; $display("FAIL b2b_grant op=%0d got %b want %b", op, grant, 4'(1 << w)); end
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if (ack !== 4'(1 << e.idx) || z !== e.z) begin
        miscompares++; $display("FAIL b2b_result op=%0d ack=%b z=%h want %b/%h", op, ack, z, 4'(1 << e.idx), e.z);
      end
      if (op == 1) req = '0;
      @(negedge clk);
      m_last = w;
    end
    vectors++;
    if (op_count !== 16'd3) begin miscompares++; $display("FAIL b2b_count got %0d want 3", op_count); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_latch();
    test_reset_mid();
    test_wrap();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/and_share_arbiter.md
AND_SHARE_ARBITER -- requirements
Module: and_share_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, SHALL set the number of requesters sharing the AND unit (2..8).
REQ-002 Parameter W, default 8, SHALL set the operand and result width in bits.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 req  input  N_REQ  SHALL carry per-requester operation requests, held high until that requester's ack.
REQ-006 x  input  N_REQ*W  SHALL carry packed operand A; requester i uses bits [i*W +: W].
REQ-007 y  input  N_REQ*W  SHALL carry packed operand B; requester i uses bits [i*W +: W].
REQ-008 grant  output  N_REQ  SHALL be the one-hot owner of the shared unit, all-zero when idle.
REQ-009 ack  output  N_REQ  SHALL give a one-cycle completion pulse to the granted requester.
REQ-010 z  output  W  SHALL present the shared AND result, valid while z_valid=1.
REQ-011 z_valid  output  1  SHALL be high for exactly the DONE cycle.
REQ-012 busy  output  1  SHALL be high whenever state is not IDLE.
REQ-013 op_count  output  16  SHALL count completed operations.

Function
REQ-014 The FSM SHALL have three states: IDLE, EXEC and DONE, encoded in 2 bits.
REQ-015 IDLE: when any req bit is 1 at a rising edge, the FSM SHALL move to EXEC, register a one-hot grant, and latch x and y of the winner; otherwise it SHALL stay in IDLE.
REQ-016 Winner selection SHALL be round-robin: search starts at index (last+1) mod N_REQ and ascends with wrap-around.
REQ-017 EXEC SHALL last exactly one cycle; at its closing edge z SHALL be registered as latched_x & latched_y (bitwise, W bits) and the FSM SHALL move to DONE.
REQ-018 DONE SHALL last exactly one cycle, with ack[winner]=1, z_valid=1 and grant unchanged.
REQ-019 At the DONE exit edge: last<=winner, grant<=0, op_count<=op_count+1 (wraps 0xFFFF->0x0000), and the FSM SHALL go to IDLE.
REQ-020 Latency: if req is sampled at edge k, grant SHALL be visible after k and ack/z_valid after k+1; throughput SHALL be one operation per 3 cycles.
REQ-021 Deasserting req or changing x/y during EXEC/DONE SHALL NOT abort the operation or alter z (operands are latched).
REQ-022 A requester still asserting req after its ack SHALL be treated as a new request, subject to round-robin.
REQ-023 z SHALL hold its last value outside DONE; only z_valid qualifies it.
REQ-024 Simultaneous requests SHALL be resolved by REQ-016 only; no requester SHALL wait more than N_REQ-1 operations.

Reset
REQ-025 While rst_n=0: state=IDLE, grant=0, ack=0, z=0, z_valid=0, busy=0, op_count=0, last=N_REQ-1 (so requester 0 wins first).
REQ-026 Reset asserted mid-operation SHALL abandon it immediately, with no ack and no op_count increment.
REQ-027 After rst_n deasserts, the first arbitration SHALL occur at the first rising edge where rst_n=1.

Structure
REQ-028 A shared package SHALL hold the state typedef (IDLE/EXEC/DONE) and the default N_REQ, W and counter-width constants.
REQ-029 Round-robin selection SHALL be a sub-module rr_pick, taking req and last and returning a one-hot winner and an any-request flag.
REQ-030 The AND datapath SHALL be the registered stage inside and_share_arbiter; no separate module.

Verification
REQ-031 Reset, then req=4'b0001, x0=8'hF0, y0=8'h3C -> grant=0001 one edge later, ack[0]=1, z=8'h30, z_valid=1 one cycle after that, op_count=1.
REQ-032 req=4'b1111 held for 12 cycles -> grant order 0,1,2,3 (each 3 cycles), then 0 again; op_count=4 after 12 cycles.
REQ-033 Requester 2 (x2=8'hFF, y2=8'hAA) granted, then x2 changed to 8'h00 and req[2] dropped during EXEC -> z=8'hAA and ack[2] pulses once.
REQ-034 rst_n pulled low during EXEC of requester 1 -> no ack, all outputs 0 immediately; after release with req=4'b0010 -> requester 1 granted next.
REQ-035 op_count preloaded via 65535 operations -> next completion gives op_count=0x0000.
REQ-036 req=4'b1001 after last=0 -> requester 3 is granted before requester 0.
